// File: rtl/toy_ld_resp.sv
// toy_ld_resp: load response unit sitting after the load-address stage.
// Accepts a resolved load, issues a word-aligned memory read with a shifted
// byte strobe, tracks up to DEPTH outstanding loads in program order, captures
// in-order memory acks, then aligns and sign/zero-extends the returned word
// and presents an in-order writeback. Illegal-funct3 or misaligned loads never
// reach memory and complete with m_wb_err set.
//
// Ports:
//   clk, rst_n          clock; synchronous reset, active-high despite the name
//   s_req_*             load request (valid/ready, addr, funct3, rd, rd_en, lsid)
//   m_mem_req_*         memory read request (valid/ready, word addr, byte strobe)
//   s_mem_ack_*         in-order read data, no backpressure
//   m_wb_*              in-order writeback (valid/ready, data, rd, rd_en, lsid, err)
//
// Optional feature macro: TOY_LD_RESP_BYPASS_EN
//   When defined, an ack that lands on a pending head entry is aligned and
//   presented on m_wb in the same cycle; if m_wb_rdy is high the head pops
//   without ever storing the data.
module toy_ld_resp #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned RD_WIDTH   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_req_vld,
   output logic                  s_req_rdy,
   input  logic [ADDR_WIDTH-1:0] s_req_addr,
   input  logic [2:0]            s_req_funct3,
   input  logic [RD_WIDTH-1:0]   s_req_rd,
   input  logic                  s_req_rd_en,
   input  logic [ID_WIDTH-1:0]   s_req_lsid,
   output logic                  m_mem_req_vld,
   input  logic                  m_mem_req_rdy,
   output logic [ADDR_WIDTH-1:0] m_mem_req_addr,
   output logic [3:0]            m_mem_req_strb,
   input  logic                  s_mem_ack_vld,
   input  logic [DATA_WIDTH-1:0] s_mem_ack_data,
   output logic                  m_wb_vld,
   input  logic                  m_wb_rdy,
   output logic [DATA_WIDTH-1:0] m_wb_data,
   output logic [RD_WIDTH-1:0]   m_wb_rd,
   output logic                  m_wb_rd_en,
   output logic [ID_WIDTH-1:0]   m_wb_lsid,
   output logic                  m_wb_err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   // Entry storage
   logic                  vld_q   [DEPTH];
   logic                  vld_d   [DEPTH];
   logic                  done_q  [DEPTH];
   logic                  done_d  [DEPTH];
   logic                  err_q   [DEPTH];
   logic                  err_d   [DEPTH];
   logic [2:0]            f3_q    [DEPTH];
   logic [2:0]            f3_d    [DEPTH];
   logic [1:0]            off_q   [DEPTH];
   logic [1:0]            off_d   [DEPTH];
   logic [RD_WIDTH-1:0]   rd_q    [DEPTH];
   logic [RD_WIDTH-1:0]   rd_d    [DEPTH];
   logic                  rd_en_q [DEPTH];
   logic                  rd_en_d [DEPTH];
   logic [ID_WIDTH-1:0]   lsid_q  [DEPTH];
   logic [ID_WIDTH-1:0]   lsid_d  [DEPTH];
   logic [DATA_WIDTH-1:0] data_q  [DEPTH];
   logic [DATA_WIDTH-1:0] data_d  [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             req_bad;
   logic [3:0]       base_strb;
   logic             full;
   logic             push;
   logic             pop;
   logic             ack_hit;
   logic [PTR_W-1:0] ack_idx;
   logic             store_ack;
   logic             head_vld;
   logic             head_done;
   logic             head_err;
   logic             byp;
   logic [DATA_WIDTH-1:0] wb_word;

   // Align and extend a returned word for the given funct3 and byte offset.
   function automatic logic [DATA_WIDTH-1:0] align_f(input logic [2:0]            f3,
                                                     input logic [1:0]            off,
                                                     input logic [DATA_WIDTH-1:0] word);
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] res;
      sh = word >> {off, 3'b000};
      case (f3)
         3'd0:    res = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         3'd4:    res = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
         3'd1:    res = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         3'd5:    res = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
         3'd2:    res = sh;
         default: res = '0;
      endcase
      return res;
   endfunction

   // Request legality and base byte strobe
   always_comb begin
      req_bad   = 1'b0;
      base_strb = 4'h0;
      case (s_req_funct3)
         3'd0, 3'd4: base_strb = 4'h1;
         3'd1, 3'd5: begin
            base_strb = 4'h3;
            req_bad   = s_req_addr[0];
         end
         3'd2: begin
            base_strb = 4'hf;
            req_bad   = |s_req_addr[1:0];
         end
         default: req_bad = 1'b1;
      endcase
   end

   assign full           = (count_q == CNT_W'(DEPTH));
   assign m_mem_req_addr = {s_req_addr[ADDR_WIDTH-1:2], 2'b00};
   assign m_mem_req_strb = base_strb << s_req_addr[1:0];
   // Handshakes are held off while reset is asserted so outputs read as idle.
   assign m_mem_req_vld  = ~rst_n & s_req_vld & ~full & ~req_bad;
   assign s_req_rdy      = ~rst_n & ~full & (req_bad | m_mem_req_rdy);
   assign push           = s_req_vld & s_req_rdy;

   // Oldest entry still waiting for memory data; only state from before this
   // cycle is scanned, so a same-cycle push can never be matched.
   always_comb begin
      ack_hit = 1'b0;
      ack_idx = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!ack_hit && vld_q[head_q + PTR_W'(i)] && !err_q[head_q + PTR_W'(i)] &&
             !done_q[head_q + PTR_W'(i)]) begin
            ack_hit = 1'b1;
            ack_idx = head_q + PTR_W'(i);
         end
      end
   end

   assign head_vld  = vld_q[head_q];
   assign head_done = done_q[head_q];
   assign head_err  = err_q[head_q];

`ifdef TOY_LD_RESP_BYPASS_EN
   assign byp = head_vld & ~head_err & ~head_done & s_mem_ack_vld;
`else
   assign byp = 1'b0;
`endif

   // Writeback view of the head entry; payload reads as zero when idle.
   assign wb_word    = byp ? s_mem_ack_data : data_q[head_q];
   assign m_wb_vld   = ~rst_n & head_vld & (head_done | byp);
   assign m_wb_err   = m_wb_vld & head_err;
   assign m_wb_data  = (m_wb_vld & ~head_err) ? align_f(f3_q[head_q], off_q[head_q], wb_word)
                                              : '0;
   assign m_wb_rd    = m_wb_vld ? rd_q[head_q] : '0;
   assign m_wb_rd_en = m_wb_vld & rd_en_q[head_q];
   assign m_wb_lsid  = m_wb_vld ? lsid_q[head_q] : '0;
   assign pop        = m_wb_vld & m_wb_rdy;
   // A bypassed ack that pops immediately is never written into the entry.
   assign store_ack  = s_mem_ack_vld & ack_hit & ~(byp & pop);

   // Next-state for pointers, count and entries
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      vld_d   = vld_q;
      done_d  = done_q;
      err_d   = err_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rd_d    = rd_q;
      rd_en_d = rd_en_q;
      lsid_d  = lsid_q;
      data_d  = data_q;

      if (store_ack) begin
         data_d[ack_idx] = s_mem_ack_data;
         done_d[ack_idx] = 1'b1;
      end

      if (pop) begin
         vld_d[head_q]  = 1'b0;
         done_d[head_q] = 1'b0;
         head_d         = head_q + PTR_W'(1);
      end

      if (push) begin
         vld_d[tail_q]   = 1'b1;
         done_d[tail_q]  = req_bad;
         err_d[tail_q]   = req_bad;
         f3_d[tail_q]    = s_req_funct3;
         off_d[tail_q]   = s_req_addr[1:0];
         rd_d[tail_q]    = s_req_rd;
         rd_en_d[tail_q] = s_req_rd_en;
         lsid_d[tail_q]  = s_req_lsid;
         data_d[tail_q]  = '0;
         tail_d          = tail_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State registers; reset discards every outstanding load.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            vld_q[i]   <= 1'b0;
            done_q[i]  <= 1'b0;
            err_q[i]   <= 1'b0;
            f3_q[i]    <= '0;
            off_q[i]   <= '0;
            rd_q[i]    <= '0;
            rd_en_q[i] <= 1'b0;
            lsid_q[i]  <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         err_q   <= err_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rd_q    <= rd_d;
         rd_en_q <= rd_en_d;
         lsid_q  <= lsid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_toy_ld_resp.sv
// Testbench for toy_ld_resp: table of single-load vectors plus hand-written
// multi-cycle sequences; writebacks are checked against a scoreboard queue
// filled as requests are accepted.
module tb_toy_ld_resp;

   logic        clk;
   logic        rst_n;
   logic        s_req_vld;
   logic        s_req_rdy;
   logic [31:0] s_req_addr;
   logic [2:0]  s_req_funct3;
   logic [5:0]  s_req_rd;
   logic        s_req_rd_en;
   logic [7:0]  s_req_lsid;
   logic        m_mem_req_vld;
   logic        m_mem_req_rdy;
   logic [31:0] m_mem_req_addr;
   logic [3:0]  m_mem_req_strb;
   logic        s_mem_ack_vld;
   logic [31:0] s_mem_ack_data;
   logic        m_wb_vld;
   logic        m_wb_rdy;
   logic [31:0] m_wb_data;
   logic [5:0]  m_wb_rd;
   logic        m_wb_rd_en;
   logic [7:0]  m_wb_lsid;
   logic        m_wb_err;

   toy_ld_resp dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_req_vld      (s_req_vld),
      .s_req_rdy      (s_req_rdy),
      .s_req_addr     (s_req_addr),
      .s_req_funct3   (s_req_funct3),
      .s_req_rd       (s_req_rd),
      .s_req_rd_en    (s_req_rd_en),
      .s_req_lsid     (s_req_lsid),
      .m_mem_req_vld  (m_mem_req_vld),
      .m_mem_req_rdy  (m_mem_req_rdy),
      .m_mem_req_addr (m_mem_req_addr),
      .m_mem_req_strb (m_mem_req_strb),
      .s_mem_ack_vld  (s_mem_ack_vld),
      .s_mem_ack_data (s_mem_ack_data),
      .m_wb_vld       (m_wb_vld),
      .m_wb_rdy       (m_wb_rdy),
      .m_wb_data      (m_wb_data),
      .m_wb_rd        (m_wb_rd),
      .m_wb_rd_en     (m_wb_rd_en),
      .m_wb_lsid      (m_wb_lsid),
      .m_wb_err       (m_wb_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] ack;
      logic [3:0]  strb;
      logic        bad;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  rd;
      logic        rd_en;
      logic [7:0]  lsid;
      logic        err;
   } exp_t;

   localparam int NVEC = 13;

   vec_t        vecs [NVEC];
   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  lsid_ctr = 8'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a request (call right after a negedge); record its expected
   // writeback if the DUT accepts it.
   task automatic send_req(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      s_req_vld    = 1'b1;
      s_req_addr   = addr;
      s_req_funct3 = f3;
      s_req_rd     = lsid_ctr[5:0];
      s_req_rd_en  = ~lsid_ctr[0];
      s_req_lsid   = lsid_ctr;
      #1;
      if (s_req_rdy) begin
         e.data  = exp_data;
         e.rd    = lsid_ctr[5:0];
         e.rd_en = ~lsid_ctr[0];
         e.lsid  = lsid_ctr;
         e.err   = exp_err;
         exp_q.push_back(e);
         lsid_ctr = lsid_ctr + 8'd1;
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      check32(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Writeback monitor: sampled well after the drive point, before the edge.
   always @(negedge clk) begin
      #4;
      if (m_wb_vld && m_wb_rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got lsid %h data %h expected no writeback",
                     m_wb_lsid, m_wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            check32("wb_data", m_wb_data, mon_e.data);
            check1("wb_err", m_wb_err, mon_e.err);
            check32("wb_lsid", {24'd0, m_wb_lsid}, {24'd0, mon_e.lsid});
            check32("wb_rd", {26'd0, m_wb_rd}, {26'd0, mon_e.rd});
            check1("wb_rd_en", m_wb_rd_en, mon_e.rd_en);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          addr          f3    ack            strb  bad   expected wb data
      vecs[0]  = '{32'h0000_1000, 3'd2, 32'hDEAD_BEEF, 4'hf, 1'b0, 32'hDEAD_BEEF};
      vecs[1]  = '{32'h0000_2003, 3'd0, 32'h80FF_FFFF, 4'h8, 1'b0, 32'hFFFF_FF80};
      vecs[2]  = '{32'h0000_2003, 3'd4, 32'h80FF_FFFF, 4'h8, 1'b0, 32'h0000_0080};
      vecs[3]  = '{32'h0000_3001, 3'd1, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
      vecs[4]  = '{32'h0000_4002, 3'd5, 32'hABCD_1234, 4'hc, 1'b0, 32'h0000_ABCD};
      vecs[5]  = '{32'h0000_4002, 3'd1, 32'h8BCD_1234, 4'hc, 1'b0, 32'hFFFF_8BCD};
      vecs[6]  = '{32'h0000_5001, 3'd0, 32'h1234_56F0, 4'h2, 1'b0, 32'h0000_0056};
      vecs[7]  = '{32'h0000_6000, 3'd3, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
      vecs[8]  = '{32'h0000_6000, 3'd6, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
      vecs[9]  = '{32'h0000_6000, 3'd7, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
      vecs[10] = '{32'h0000_7002, 3'd2, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
      vecs[11] = '{32'h0000_8000, 3'd1, 32'h0000_F00F, 4'h3, 1'b0, 32'hFFFF_F00F};
      vecs[12] = '{32'h0000_9002, 3'd4, 32'h00AB_0000, 4'h4, 1'b0, 32'h0000_00AB};

      rst_n          = 1'b1;
      s_req_vld      = 1'b0;
      s_req_addr     = 32'd0;
      s_req_funct3   = 3'd0;
      s_req_rd       = 6'd0;
      s_req_rd_en    = 1'b0;
      s_req_lsid     = 8'd0;
      m_mem_req_rdy  = 1'b1;
      s_mem_ack_vld  = 1'b0;
      s_mem_ack_data = 32'd0;
      m_wb_rdy       = 1'b1;

      // Outputs while in reset: handshakes idle, address/strobe follow inputs.
      repeat (2) @(negedge clk);
      s_req_vld    = 1'b1;
      s_req_addr   = 32'h0000_1234;
      s_req_funct3 = 3'd2;
      #1;
      check1("rst_req_rdy", s_req_rdy, 1'b0);
      check1("rst_mem_vld", m_mem_req_vld, 1'b0);
      check1("rst_wb_vld", m_wb_vld, 1'b0);
      check32("rst_wb_data", m_wb_data, 32'd0);
      check32("rst_mem_addr", m_mem_req_addr, 32'h0000_1234);
      check32("rst_mem_strb", {28'd0, m_mem_req_strb}, 32'hf);
      @(negedge clk);
      s_req_vld = 1'b0;
      rst_n     = 1'b0;

      // Single-load vectors
      for (int v = 0; v < NVEC; v++) begin
         @(negedge clk);
         m_mem_req_rdy = ~vecs[v].bad;
         send_req(vecs[v].addr, vecs[v].f3, vecs[v].data, vecs[v].bad);
         check1($sformatf("v%0d_req_rdy", v), s_req_rdy, 1'b1);
         check1($sformatf("v%0d_mem_vld", v), m_mem_req_vld, ~vecs[v].bad);
         check32($sformatf("v%0d_mem_addr", v), m_mem_req_addr,
                 {vecs[v].addr[31:2], 2'b00});
         if (!vecs[v].bad)
            check32($sformatf("v%0d_mem_strb", v), {28'd0, m_mem_req_strb},
                    {28'd0, vecs[v].strb});
         check1($sformatf("v%0d_wb_idle", v), m_wb_vld, 1'b0);
         @(negedge clk);
         s_req_vld     = 1'b0;
         m_mem_req_rdy = 1'b1;
         if (vecs[v].bad) begin
            #1;
            check1($sformatf("v%0d_err_lat", v), m_wb_vld, 1'b1);
         end else begin
            @(negedge clk);
            @(negedge clk);
            s_mem_ack_vld  = 1'b1;
            s_mem_ack_data = vecs[v].ack;
            #1;
`ifndef TOY_LD_RESP_BYPASS_EN
            check1($sformatf("v%0d_ack_lat0", v), m_wb_vld, 1'b0);
`endif
            @(negedge clk);
            s_mem_ack_vld = 1'b0;
            #1;
`ifndef TOY_LD_RESP_BYPASS_EN
            check1($sformatf("v%0d_ack_lat1", v), m_wb_vld, 1'b1);
`endif
         end
         wait_drain($sformatf("v%0d_drain", v));
      end

      // Error load stays in order behind an older pending LW.
      @(negedge clk);
      send_req(32'h0000_1000, 3'd2, 32'h1111_2222, 1'b0);
      check1("ord_lw_rdy", s_req_rdy, 1'b1);
      @(negedge clk);
      m_mem_req_rdy = 1'b0;
      send_req(32'h0000_3001, 3'd1, 32'd0, 1'b1);
      check1("ord_bad_rdy", s_req_rdy, 1'b1);
      check1("ord_bad_mem_vld", m_mem_req_vld, 1'b0);
      @(negedge clk);
      s_req_vld     = 1'b0;
      m_mem_req_rdy = 1'b1;
      #1;
      check1("ord_hold", m_wb_vld, 1'b0);
      @(negedge clk);
      s_mem_ack_vld  = 1'b1;
      s_mem_ack_data = 32'h1111_2222;
      @(negedge clk);
      s_mem_ack_vld = 1'b0;
      wait_drain("ord_drain");

      // Fill to DEPTH with writeback stalled; fifth request must be refused.
      m_wb_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         send_req(32'h0000_2000 + 32'(4 * i), 3'd2, 32'(i + 1), 1'b0);
         check1($sformatf("fill%0d_rdy", i), s_req_rdy, 1'b1);
      end
      @(negedge clk);
      send_req(32'h0000_3000, 3'd2, 32'h5555_5555, 1'b0);
      check1("full_req_rdy", s_req_rdy, 1'b0);
      check1("full_mem_vld", m_mem_req_vld, 1'b0);
      @(negedge clk);
      s_req_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_mem_ack_vld  = 1'b1;
         s_mem_ack_data = 32'(i + 1);
         @(negedge clk);
      end
      s_mem_ack_vld = 1'b0;
      #1;
      check1("full_wb_vld", m_wb_vld, 1'b1);
      m_wb_rdy = 1'b1;
      wait_drain("full_drain");

      // Push, ack and pop in the same cycle right after a full FIFO drains one.
      m_wb_rdy = 1'b0;
      @(negedge clk);
      send_req(32'h0000_5000, 3'd2, 32'h0000_00A0, 1'b0);
      @(negedge clk);
      s_mem_ack_vld  = 1'b1;
      s_mem_ack_data = 32'h0000_00A0;
      send_req(32'h0000_5004, 3'd2, 32'h0000_00A1, 1'b0);
      @(negedge clk);
      s_mem_ack_vld = 1'b0;
      send_req(32'h0000_5008, 3'd2, 32'h0000_00A2, 1'b0);
      @(negedge clk);
      send_req(32'h0000_500C, 3'd2, 32'h0000_00A3, 1'b0);
      @(negedge clk);
      m_wb_rdy       = 1'b1;
      s_mem_ack_vld  = 1'b1;
      s_mem_ack_data = 32'h0000_00A1;
      send_req(32'h0000_5010, 3'd2, 32'h0000_00A4, 1'b0);
      check1("same_full_rdy", s_req_rdy, 1'b0);
      check1("same_full_wb_vld", m_wb_vld, 1'b1);
      @(negedge clk);
      s_mem_ack_data = 32'h0000_00A2;
      send_req(32'h0000_5010, 3'd2, 32'h0000_00A4, 1'b0);
      check1("same_freed_rdy", s_req_rdy, 1'b1);
      check1("same_pop_vld", m_wb_vld, 1'b1);
      @(negedge clk);
      s_mem_ack_vld = 1'b0;
      m_wb_rdy      = 1'b0;
      send_req(32'h0000_5014, 3'd2, 32'h0000_00A5, 1'b0);
      check1("same_count3_rdy", s_req_rdy, 1'b1);
      @(negedge clk);
      send_req(32'h0000_5018, 3'd2, 32'h0000_00A6, 1'b0);
      check1("same_refull_rdy", s_req_rdy, 1'b0);
      @(negedge clk);
      s_req_vld      = 1'b0;
      m_wb_rdy       = 1'b1;
      s_mem_ack_vld  = 1'b1;
      s_mem_ack_data = 32'h0000_00A3;
      @(negedge clk);
      s_mem_ack_data = 32'h0000_00A4;
      @(negedge clk);
      s_mem_ack_data = 32'h0000_00A5;
      @(negedge clk);
      s_mem_ack_vld = 1'b0;
      wait_drain("same_drain");

      // Reset with outstanding loads; stale acks afterwards must be dropped.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         send_req(32'h0000_6000 + 32'(4 * i), 3'd2, 32'hFFFF_FFFF, 1'b0);
      end
      @(negedge clk);
      s_req_vld = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      s_mem_ack_vld  = 1'b1;
      s_mem_ack_data = 32'hBAD0_0000;
      #1;
      check1("stale0_wb_vld", m_wb_vld, 1'b0);
      @(negedge clk);
      s_mem_ack_data = 32'hBAD1_1111;
      #1;
      check1("stale1_wb_vld", m_wb_vld, 1'b0);
      @(negedge clk);
      s_mem_ack_vld = 1'b0;
      #1;
      check1("stale2_wb_vld", m_wb_vld, 1'b0);
      @(negedge clk);
      send_req(32'h0000_4002, 3'd5, 32'h0000_ABCD, 1'b0);
      check1("post_rst_rdy", s_req_rdy, 1'b1);
      check32("post_rst_strb", {28'd0, m_mem_req_strb}, 32'hc);
      @(negedge clk);
      s_req_vld = 1'b0;
      #1;
      check1("post_rst_wb_idle", m_wb_vld, 1'b0);
      @(negedge clk);
      s_mem_ack_vld  = 1'b1;
      s_mem_ack_data = 32'hABCD_1234;
      @(negedge clk);
      s_mem_ack_vld = 1'b0;
      wait_drain("post_rst_drain");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/toy_ld_resp.md
Name: toy_ld_resp

Overview:
- Downstream neighbour of the load-address stage.
- Accepts a resolved load (address, funct3, rd, lsid) and issues a word-aligned memory read with a shifted byte strobe.
- Tracks up to DEPTH outstanding loads in order, captures in-order memory acks, then aligns and sign/zero-extends the data.
- Presents an in-order writeback to the register-file/commit side; loads with an illegal funct3 or bad alignment complete with an error flag and never reach memory.

Parameters:
DEPTH, 4, outstanding-load entries (power of two, >=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, memory/register data width (fixed 32 for RV32 loads)
ID_WIDTH, 8, lsid width
RD_WIDTH, 6, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high (asserted when 1 despite the name)
s_req_vld  in  1  load request valid
s_req_rdy  out  1  load request ready
s_req_addr  in  ADDR_WIDTH  raw byte address
s_req_funct3  in  3  RV load funct3
s_req_rd  in  RD_WIDTH  destination register
s_req_rd_en  in  1  destination write enable
s_req_lsid  in  ID_WIDTH  load/store id
m_mem_req_vld  out  1  memory read valid
m_mem_req_rdy  in  1  memory read ready
m_mem_req_addr  out  ADDR_WIDTH  {s_req_addr[ADDR_WIDTH-1:2],2'b00}
m_mem_req_strb  out  4  byte strobe shifted by addr[1:0]
s_mem_ack_vld  in  1  read data valid (in order, no backpressure)
s_mem_ack_data  in  DATA_WIDTH  read word
m_wb_vld  out  1  writeback valid
m_wb_rdy  in  1  writeback ready
m_wb_data  out  DATA_WIDTH  aligned/extended result
m_wb_rd  out  RD_WIDTH  destination register
m_wb_rd_en  out  1  destination write enable
m_wb_lsid  out  ID_WIDTH  lsid
m_wb_err  out  1  misaligned or illegal-funct3 load

Behaviour:
- Legality check on the request:
  - LB/LBU: any offset.
  - LH/LHU: addr[0]==0.
  - LW: addr[1:0]==0.
  - funct3 3/6/7: illegal.
  - Illegal or misaligned requests set bad=1.
- Base strobe: LB/LBU=4'h1, LH/LHU=4'h3, LW=4'hf. m_mem_req_strb = base << addr[1:0], truncated to 4 bits.
- Handshake:
  - m_mem_req_vld = s_req_vld & ~full & ~bad.
  - s_req_rdy = ~full & (bad | m_mem_req_rdy).
  - Both are combinational; no bubble between requests.
- Push on s_req_vld & s_req_rdy. The entry at the tail stores funct3, addr[1:0], rd, rd_en, lsid, err=bad, done=bad, data=0.
- Ack capture: on s_mem_ack_vld, write data into the oldest valid entry with err==0 & done==0, and set done.
  - An ack with no such entry is dropped.
  - An ack never matches an entry pushed in the same cycle.
- Writeback:
  - m_wb_vld = head valid & head done. Pop on m_wb_vld & m_wb_rdy.
  - Latency: ack in cycle N gives m_wb_vld in cycle N+1 earliest. An error entry gives m_wb_vld the cycle after its push.
- Alignment: sh = head.data >> (8*offset).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: sh.
  - err entries: m_wb_data=0, m_wb_err=1.
- Full when count==DEPTH. Push, ack and pop may all happen in one cycle. A push while full is impossible (rdy=0). A pop while full frees a slot from the next cycle.
- Pointers are log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
- Reset:
  - head, tail and count are 0; all entry valid/done bits are cleared.
  - All outputs are 0 except m_mem_req_addr/strb, which follow the inputs.
  - Acks for requests issued before reset are dropped.

Optional Feature:
- Macro TOY_LD_RESP_BYPASS_EN.
- Defined: when head is valid, head err==0, head done==0 and s_mem_ack_vld is high, the aligned ack data drives m_wb same cycle (zero latency).
  - If m_wb_rdy is high, the head pops without storing.
  - If m_wb_rdy is low, the data is stored as normal.
- Undefined: ack-to-writeback latency is always >=1 cycle as above.

Test Plan:
- LW addr 0x1000, mem rdy=1; ack 0xDEADBEEF 3 cycles later -> mem addr 0x1000 strb 4'hf; wb data 0xDEADBEEF, err=0, 1 cycle after ack.
- LB addr 0x2003, ack 0x80FFFFFF -> strb 4'h8; wb data 0xFFFFFF80. Same with LBU -> 0x00000080.
- LH addr 0x3001 -> no mem request, s_req_rdy=1 regardless of mem rdy; wb err=1, data=0, next cycle. Stays in order behind an older pending LW.
- 4 LW pushes with no ack, m_wb_rdy=0 -> s_req_rdy=0 on 5th. Ack 4 words 0x1,0x2,0x3,0x4 -> wb in lsid order 0..3 with matching data.
- Same cycle: push, ack to head, pop with full FIFO -> count unchanged; no data lost or duplicated.
- Assert reset with 3 outstanding, then send 2 stale acks -> m_wb_vld stays 0; the next LHU 0x4002 with ack 0xABCD1234 gives wb 0x0000ABCD.
